// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl: parses checksummed command frames from the UART byte stream
// and drives the DDS configuration (tuning word, amplitude, mode).
// Frame: A5 | CMD | payload (N bytes, MSB first) | CHK, CHK = XOR(CMD, payload).
// The tuning word is applied only on a phase-accumulator wrap.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for SYNC (0xA5); other bytes dropped
// S_CMD     | expecting command byte
// S_PAYLOAD | shifting payload bytes into the shadow register
// S_CHECK   | expecting checksum byte; commit or reject
module dds_cfg_ctrl #(
    parameter int              PW       = 32,
    parameter logic [PW-1:0]   RESET_TW = PW'(32'h0100_0000),
    parameter int              TIMEOUT  = 100000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_phase_wrap,
    output logic [PW-1:0] o_tuning_word,
    output logic [7:0]    o_amplitude,
    output logic          o_ook_en,
    output logic          o_out_en,
    output logic          o_tw_pending,
    output logic          o_busy,
    output logic          o_cfg_ok,
    output logic          o_cfg_err
);

    localparam int NB   = PW / 8;
    localparam int CW   = $clog2(NB + 1);
    localparam int TMW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CMD     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CHECK   = 2'd3;

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] CMD_TW   = 8'h01;
    localparam logic [7:0] CMD_AMP  = 8'h02;
    localparam logic [7:0] CMD_MODE = 8'h03;

    logic [1:0]    r_state;
    logic [7:0]    r_cmd;
    logic [7:0]    r_xor;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_shadow;
    logic [TMW-1:0] r_tmo_cnt;
    logic          r_busy;
    logic          r_cfg_ok;
    logic          r_cfg_err;
    logic [7:0]    r_amp;
    logic          r_ook_en;
    logic          r_out_en;
    logic [PW-1:0] r_tw;
    logic [PW-1:0] r_tw_commit;
    logic          r_tw_pending;

    logic [1:0]    w_state_nxt;
    logic          w_timeout;
    logic          w_known;
    logic          w_accept;

    // A byte in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_rx_valid
                       && (r_tmo_cnt == TMW'(TIMEOUT - 1));
    assign w_known   = (i_rx_data == CMD_TW) || (i_rx_data == CMD_AMP)
                       || (i_rx_data == CMD_MODE);
    assign w_accept  = (r_state == S_CHECK) && i_rx_valid && (i_rx_data == r_xor);

    // Next-state decode for the frame parser.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (i_rx_valid) begin
            case (r_state)
                S_IDLE:    if (i_rx_data == SYNC) w_state_nxt = S_CMD;
                S_CMD:     w_state_nxt = w_known ? S_PAYLOAD : S_IDLE;
                S_PAYLOAD: if (r_cnt == CW'(1)) w_state_nxt = S_CHECK;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Parser datapath, status pulses, amplitude and mode registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_xor     <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_busy    <= 1'b0;
            r_cfg_ok  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_amp     <= 8'hFF;
            r_ook_en  <= 1'b0;
            r_out_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_cfg_ok  <= 1'b0;
            r_cfg_err <= w_timeout;
            if (i_rx_valid) begin
                case (r_state)
                    S_CMD: begin
                        if (w_known) begin
                            r_cmd    <= i_rx_data;
                            r_xor    <= i_rx_data;
                            r_cnt    <= (i_rx_data == CMD_TW) ? CW'(NB) : CW'(1);
                            r_shadow <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        r_shadow <= {r_shadow[PW-9:0], i_rx_data};
                        r_xor    <= r_xor ^ i_rx_data;
                        r_cnt    <= r_cnt - CW'(1);
                    end
                    S_CHECK: begin
                        if (w_accept) begin
                            r_cfg_ok <= 1'b1;
                            if (r_cmd == CMD_AMP) r_amp <= r_shadow[7:0];
                            if (r_cmd == CMD_MODE) begin
                                r_ook_en <= r_shadow[0];
                                r_out_en <= r_shadow[1];
                            end
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Inter-byte idle counter; cleared by every byte and held at zero in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_IDLE) || i_rx_valid || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMW'(1);
        end
    end

    // Tuning word staging: a fresh commit takes priority over a coincident
    // wrap, so only the newest word is ever applied and never on its commit edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tw         <= RESET_TW;
            r_tw_commit  <= '0;
            r_tw_pending <= 1'b0;
        end else if (w_accept && (r_cmd == CMD_TW)) begin
            r_tw_commit  <= r_shadow;
            r_tw_pending <= 1'b1;
        end else if (r_tw_pending && i_phase_wrap) begin
            r_tw         <= r_tw_commit;
            r_tw_pending <= 1'b0;
        end
    end

    assign o_tuning_word = r_tw;
    assign o_amplitude   = r_amp;
    assign o_ook_en      = r_ook_en;
    assign o_out_en      = r_out_en;
    assign o_tw_pending  = r_tw_pending;
    assign o_busy        = r_busy;
    assign o_cfg_ok      = r_cfg_ok;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Directed bench for dds_cfg_ctrl; inputs change and outputs are checked on
// the falling edge, pulses are tallied 1 ns after each rising edge.
module tb_dds_cfg_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        phase_wrap;
    logic [31:0] tuning_word;
    logic [7:0]  amplitude;
    logic        ook_en, out_en, tw_pending, busy, cfg_ok, cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int base_ok, base_err, k;

    dds_cfg_ctrl #(.PW(32), .RESET_TW(32'h0100_0000), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_phase_wrap(phase_wrap), .o_tuning_word(tuning_word),
        .o_amplitude(amplitude), .o_ook_en(ook_en), .o_out_en(out_en),
        .o_tw_pending(tw_pending), .o_busy(busy), .o_cfg_ok(cfg_ok),
        .o_cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cfg_ok === 1'b1) ok_cnt++;
        if (cfg_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wrap();
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; phase_wrap = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset state, wraps with nothing pending
        chk("rst_tw", tuning_word, 32'h0100_0000);
        chk("rst_amp", amplitude, 32'hFF);
        chk("rst_ook", ook_en, 0);
        chk("rst_out", out_en, 0);
        chk("rst_pend", tw_pending, 0);
        chk("rst_busy", busy, 0);
        wrap(); wrap(); idle(1); wrap();
        chk("rst_tw_after_wrap", tuning_word, 32'h0100_0000);
        chk("rst_no_pulses", ok_cnt + err_cnt, 0);

        // Tuning word frame, applied on wrap 5 cycles after cfg_ok
        send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        chk("tw_busy", busy, 1);
        send(8'h09);
        chk("tw_ok", cfg_ok, 1);
        chk("tw_pend", tw_pending, 1);
        chk("tw_hold", tuning_word, 32'h0100_0000);
        idle(1);
        chk("tw_ok_1cyc", cfg_ok, 0);
        idle(3);
        chk("tw_hold_prewrap", tuning_word, 32'h0100_0000);
        wrap();
        chk("tw_applied", tuning_word, 32'h1234_5678);
        chk("tw_pend_clr", tw_pending, 0);
        chk("tw_ok_cnt", ok_cnt, 1);

        // Amplitude and mode
        send(8'hA5); send(8'h02); send(8'h80); send(8'h82);
        chk("amp_ok", cfg_ok, 1);
        chk("amp_val", amplitude, 32'h80);
        send(8'hA5); send(8'h03); send(8'h03); send(8'h00);
        chk("mode_ok", cfg_ok, 1);
        chk("mode_ook", ook_en, 1);
        chk("mode_out", out_en, 1);

        // Bad checksum, unknown command, stray bytes
        base_ok = ok_cnt; base_err = err_cnt;
        send(8'hA5); send(8'h02); send(8'h80); send(8'h00);
        chk("badchk_err", cfg_err, 1);
        chk("badchk_amp", amplitude, 32'h80);
        send(8'hA5); send(8'h7E);
        chk("badcmd_err", cfg_err, 1);
        chk("badcmd_busy", busy, 0);
        send(8'h00); send(8'h55); send(8'hFF); idle(1);
        chk("stray_busy", busy, 0);
        chk("bad_ok_cnt", ok_cnt - base_ok, 0);
        chk("bad_err_cnt", err_cnt - base_err, 2);

        // Timeout: cfg_err in cycle T+1 after the last byte
        send(8'hA5); send(8'h01); send(8'h12);
        k = 1;
        while (cfg_err !== 1'b1 && k < 4 * T) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycle", k, T + 1);
        chk("tmo_busy", busy, 0);
        idle(1);
        chk("tmo_err_1cyc", cfg_err, 0);

        // Byte in the expiry cycle keeps the frame alive
        base_err = err_cnt;
        send(8'hA5); send(8'h01); send(8'hAB);
        idle(T - 1);
        send(8'h34);
        chk("save_busy", busy, 1);
        send(8'h56); send(8'h78); send(8'hB0);
        chk("save_ok", cfg_ok, 1);
        chk("save_no_err", err_cnt - base_err, 0);
        wrap();
        chk("save_tw", tuning_word, 32'hAB34_5678);

        // Overwrite while pending, survival of a bad frame
        send(8'hA5); send(8'h01); send(8'h11); send(8'h11); send(8'h11); send(8'h11); send(8'h01);
        chk("ow1_pend", tw_pending, 1);
        send(8'hA5); send(8'h01); send(8'h22); send(8'h22); send(8'h22); send(8'h22); send(8'h01);
        chk("ow2_pend", tw_pending, 1);
        chk("ow_hold", tuning_word, 32'hAB34_5678);
        send(8'hA5); send(8'h01); send(8'h33); send(8'h33); send(8'h33); send(8'h33); send(8'hFF);
        chk("surv_err", cfg_err, 1);
        chk("surv_pend", tw_pending, 1);
        wrap();
        chk("ow_applied", tuning_word, 32'h2222_2222);
        chk("ow_pend_clr", tw_pending, 0);

        // Wrap on the commit edge is ignored; the next wrap applies
        send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        phase_wrap = 1'b1;
        send(8'h00);
        phase_wrap = 1'b0;
        chk("same_edge_ok", cfg_ok, 1);
        chk("same_edge_hold", tuning_word, 32'h2222_2222);
        chk("same_edge_pend", tw_pending, 1);
        idle(2);
        wrap();
        chk("same_edge_applied", tuning_word, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
